// File: rtl/adder_arbiter.sv
// Two-requester 32-bit adder sharing one 16-bit adder slice.
// Optional per-requester completion counters: ADDER_ARBITER_STATS_EN.

module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] answer,
  output logic        carry
);
  // plain 16-bit add, carry out of bit 15
  always_comb begin
    {carry, answer} = {1'b0, a} + {1'b0, b};
  end
endmodule

module adder_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_sum,
`ifdef ADDER_ARBITER_STATS_EN
  output logic        resp_carry,
  output logic [15:0] done_cnt0,
  output logic [15:0] done_cnt1
`else
  output logic        resp_carry
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    INC,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum_q;
  logic        c_lo;
  logic        c_hi;
  logic        id_q;
  logic        last_q;
  logic        valid_q;

  logic        grant0;
  logic        grant1;
  logic        hs0;
  logic        hs1;
  logic        resp_hs;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_ans;
  logic        add_c;

  // grant only in IDLE; on contention favour whoever was not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign hs0        = req0_valid & grant0;
  assign hs1        = req1_valid & grant1;
  assign resp_hs    = valid_q & resp_ready;

  assign resp_valid = valid_q;
  assign resp_sum   = sum_q;
  assign resp_carry = c_hi;
  assign resp_id    = id_q;

  // steer the shared slice according to the current half being worked on
  always_comb begin
    add_a = 16'h0000;
    add_b = 16'h0000;
    unique case (state)
      LO: begin
        add_a = op_a[15:0];
        add_b = op_b[15:0];
      end
      HI: begin
        add_a = op_a[31:16];
        add_b = op_b[31:16];
      end
      INC: begin
        add_a = sum_q[31:16];
        add_b = 16'h0001;
      end
      default: begin
        add_a = 16'h0000;
        add_b = 16'h0000;
      end
    endcase
  end

  adder16 u_add (
    .a      (add_a),
    .b      (add_b),
    .answer (add_ans),
    .carry  (add_c)
  );

  // control FSM with registered result and response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= 32'h0;
      op_b    <= 32'h0;
      sum_q   <= 32'h0;
      c_lo    <= 1'b0;
      c_hi    <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs0 || hs1) begin
            op_a   <= hs1 ? req1_a : req0_a;
            op_b   <= hs1 ? req1_b : req0_b;
            id_q   <= hs1;
            last_q <= hs1;
            state  <= LO;
          end
        end
        LO: begin
          sum_q[15:0] <= add_ans;
          c_lo        <= add_c;
          state       <= HI;
        end
        HI: begin
          sum_q[31:16] <= add_ans;
          c_hi         <= add_c;
          if (c_lo) begin
            state <= INC;
          end else begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        INC: begin
          sum_q[31:16] <= add_ans;
          c_hi         <= c_hi | add_c;
          state        <= DONE;
          valid_q      <= 1'b1;
        end
        DONE: begin
          if (resp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_ARBITER_STATS_EN
  // count completed responses per owner, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt0 <= 16'h0;
      done_cnt1 <= 16'h0;
    end else if (resp_hs) begin
      if (id_q) begin
        done_cnt1 <= done_cnt1 + 16'h1;
      end else begin
        done_cnt0 <= done_cnt0 + 16'h1;
      end
    end
  end
`else
  logic unused_hs;
  assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: reference model plus directed vectors.
// Build with +define+ADDER_ARBITER_STATS_EN to also check counters.

module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_sum;
  logic        resp_carry;
`ifdef ADDER_ARBITER_STATS_EN
  logic [15:0] done_cnt0;
  logic [15:0] done_cnt1;
`endif

  adder_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
`ifdef ADDER_ARBITER_STATS_EN
    .resp_carry (resp_carry),
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
`else
    .resp_carry (resp_carry)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic fail(input string n, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    int          t;
  } ent_t;

  ent_t q[$];
  bit   m_busy = 0;
  bit   m_last = 1;
  bit   prev_rv = 0;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
    logic [16:0] lo;
    lo = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    return lo[16] ? 4 : 3;
  endfunction

  always @(negedge clk) begin
    logic        e0;
    logic        e1;
    logic [32:0] full;
    if (rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      q.delete();
      m_busy  = 0;
      m_last  = 1;
      prev_rv = 0;
      m_cnt0  = 0;
      m_cnt1  = 0;
    end else begin
`ifdef ADDER_ARBITER_STATS_EN
      chk("cnt0", done_cnt0, m_cnt0 % 65536);
      chk("cnt1", done_cnt1, m_cnt1 % 65536);
`endif
      if (m_busy) begin
        e0 = 0;
        e1 = 0;
      end else begin
        e0 = req0_valid && (!req1_valid || m_last);
        e1 = req1_valid && (!req0_valid || !m_last);
      end
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      if (req0_valid && req0_ready) begin
        q.push_back('{0, req0_a, req0_b, cyc});
        m_last = 0;
        m_busy = 1;
      end else if (req1_valid && req1_ready) begin
        q.push_back('{1, req1_a, req1_b, cyc});
        m_last = 1;
        m_busy = 1;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          fail("resp_spurious", 1, 0);
        end else begin
          full = {1'b0, q[0].a} + {1'b0, q[0].b};
          if (!prev_rv)
            chk("latency", cyc - q[0].t, exp_lat(q[0].a, q[0].b));
          chk("sum", resp_sum, full[31:0]);
          chk("carry", resp_carry, full[32]);
          chk("id", resp_id, q[0].id);
          if (resp_ready) begin
            if (q[0].id) m_cnt1++;
            else m_cnt0++;
            void'(q.pop_front());
            m_busy = 0;
          end
        end
      end else if (q.size() > 0) begin
        if (cyc - q[0].t >= exp_lat(q[0].a, q[0].b))
          fail("resp_timeout", cyc - q[0].t, exp_lat(q[0].a, q[0].b));
      end
      prev_rv = resp_valid;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input bit id, input logic [31:0] a,
                      input logic [31:0] b, output int t_hs);
    bit got;
    got  = 0;
    t_hs = -1;
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        got  = 1;
        t_hs = cyc;
      end
    end
    if (!got) fail("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 0;
    else req0_valid = 0;
  endtask

  task automatic wait_resp(output int t_rv);
    bit got;
    got  = 0;
    t_rv = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got  = 1;
        t_rv = cyc;
      end
    end
    if (!got) fail("resp_wait_timeout", 0, 1);
  endtask

  task automatic one(input string n, input bit id, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] s,
                     input logic c, input int lat);
    int th;
    int tr;
    send(id, a, b, th);
    wait_resp(tr);
    chk({n, "_lat"}, tr - th, lat);
    chk({n, "_sum"}, resp_sum, s);
    chk({n, "_carry"}, resp_carry, c);
    chk({n, "_id"}, resp_id, id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int th;
    int tr;
    int ids[4];
    int n;
    req0_valid = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0;
    resp_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_valid", resp_valid, 0);
    chk("reset_sum", resp_sum, 0);
    chk("reset_carry", resp_carry, 0);
    chk("reset_id", resp_id, 0);
    @(posedge clk);
    #1;

    one("single", 0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 0, 3);
    one("locarry", 1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 0, 4);
    one("ovf", 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 4);
    one("hicarry", 1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 3);
    one("both", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 4);

    // back-pressure with a competing request waiting
    resp_ready = 0;
    send(0, 32'h1234_5678, 32'h1111_1111, th);
    wait_resp(tr);
    @(posedge clk);
    #1;
    req1_valid = 1;
    req1_a = 32'h0000_0010;
    req1_b = 32'h0000_0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_sum", resp_sum, 32'h2345_6789);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1;
    @(negedge clk);
    chk("bp_hs_ready1", req1_ready, 0);
    @(negedge clk);
    chk("bp_idle_ready1", req1_ready, 1);
    @(posedge clk);
    #1;
    req1_valid = 0;
    wait_resp(tr);
    chk("bp_next_sum", resp_sum, 32'h0000_0030);
    chk("bp_next_id", resp_id, 1);
    @(posedge clk);
    #1;

    // reset while the slice is working on the high half
    send(0, 32'h0000_0005, 32'h0000_0006, th);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    req1_valid = 1;
    req1_a = 32'h0000_0007;
    req1_b = 32'h0000_0008;
    @(negedge clk);
    chk("rsthi_valid", resp_valid, 0);
    chk("rsthi_idle_ready1", req1_ready, 1);
`ifdef ADDER_ARBITER_STATS_EN
    chk("rsthi_cnt0", done_cnt0, 0);
    chk("rsthi_cnt1", done_cnt1, 0);
`endif
    @(posedge clk);
    #1;
    req1_valid = 0;
    wait_resp(tr);
    chk("rsthi_next_sum", resp_sum, 32'h0000_000F);
    @(posedge clk);
    #1;

    // both requesters valid from reset: grants must alternate
    rst = 1;
    req0_valid = 1; req0_a = 32'd1;   req0_b = 32'd2;
    req1_valid = 1; req1_a = 32'd100; req1_b = 32'd200;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    n = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        ids[n] = resp_id;
        n++;
      end
    end
    chk("alt_count", n, 4);
    chk("alt_id0", ids[0], 0);
    chk("alt_id1", ids[1], 1);
    chk("alt_id2", ids[2], 0);
    chk("alt_id3", ids[3], 1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
    repeat (8) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, shared adder slice fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same widths and meanings for requester 1.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_id  output  1  index of the requester that owns the result.
REQ-011 resp_sum  output  32  (a+b) mod 2^32.
REQ-012 resp_carry  output  1  carry out of bit 31.

Function
REQ-013 Block SHALL instantiate exactly one instance of the team's 16-bit adder (inputs a, b; outputs answer, carry; no carry-in) and time-share it for all arithmetic.
REQ-014 FSM states: IDLE, LO, HI, INC, DONE.
REQ-015 IDLE: reqN_ready = grant_N; handshake = reqN_valid & reqN_ready; on handshake latch a, b, id; next state LO.
REQ-016 Arbitration: one valid requester is granted; both valid -> grant the one not granted last; last-grant pointer updates only on handshake.
REQ-017 At most one reqN_ready high per cycle; both low outside IDLE.
REQ-018 LO: adder inputs a[15:0], b[15:0]; register sum[15:0] and c_lo; next HI.
REQ-019 HI: adder inputs a[31:16], b[31:16]; register sum[31:16] and c_hi; next INC if c_lo=1, else DONE.
REQ-020 INC: adder inputs sum[31:16], 16'h0001; register sum[31:16] <= answer; c_hi <= c_hi | carry; next DONE.
REQ-021 DONE: resp_valid=1; resp_sum, resp_carry, resp_id stable while resp_valid=1 and resp_ready=0; on resp_ready=1 next IDLE.
REQ-022 Latency: handshake at cycle T -> resp_valid first high at T+3 (no low carry) or T+4 (low carry).
REQ-023 No new request accepted in the cycle resp handshake completes; earliest next acceptance is the following cycle (IDLE).
REQ-024 Back-pressure: resp_ready low holds DONE indefinitely; both reqN_ready stay low.
REQ-025 Requester SHALL hold valid and operands stable until ready; block samples operands only at handshake.
REQ-026 Wrap-around: sum is modulo 2^32; overflow reported only via resp_carry.

Reset
REQ-027 rst=1 at any edge: state <= IDLE, resp_valid=0, resp_sum=0, resp_carry=0, resp_id=0, last-grant pointer = 1 (requester 0 preferred first).
REQ-028 Reset mid-operation discards the in-flight operation; no response is produced for it.
REQ-029 While rst=1, req0_ready=req1_ready=0.

Configuration
REQ-030 Macro ADDER_ARBITER_STATS_EN.
REQ-031 Defined: add outputs done_cnt0, done_cnt1 (16 bits each), incremented on each resp handshake for the matching resp_id, wrap 16'hFFFF -> 0, reset to 0.
REQ-032 Undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-033 Single req0: a=32'h0000_0001, b=32'h0000_0002, resp_ready=1 -> resp_valid at T+3, sum=32'h0000_0003, carry=0, id=0.
REQ-034 Low carry: a=32'h0000_FFFF, b=32'h0000_0001 -> resp_valid at T+4, sum=32'h0001_0000, carry=0.
REQ-035 Full overflow: a=32'hFFFF_FFFF, b=32'h0000_0001 -> sum=32'h0000_0000, carry=1, T+4.
REQ-036 Both valid continuously from reset, resp_ready=1 -> grants alternate 0,1,0,1; resp_id matches.
REQ-037 resp_ready=0 for 10 cycles in DONE -> outputs stable, both reqN_ready=0; then resp_ready=1 -> IDLE next cycle.
REQ-038 rst asserted in HI -> next cycle IDLE, resp_valid=0, no response; with ADDER_ARBITER_STATS_EN counters read 0.
